uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and frame defaults
// used by uart_rx and, later, uart_tx.
package uart_pkg;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_START  = 3'd1;
    localparam logic [2:0] ENC_DATA   = 3'd2;
    localparam logic [2:0] ENC_PARITY = 3'd3;
    localparam logic [2:0] ENC_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ENC_IDLE,
        START  = ENC_START,
        DATA   = ENC_DATA,
        PARITY = ENC_PARITY,
        STOP   = ENC_STOP
    } state_e;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 7;

    localparam int DEF_NB_DATA = 8;
    localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; RESET_VAL sets the
// level both flops hold while in reset (1 for an idle-high serial line).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, stepping only on i_tick strobes; LSB-first 8N1 frames.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA     = DEF_NB_DATA,
    parameter int SB_TICK     = DEF_SB_TICK,
    parameter int NB_TICK_CNT = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_TICK_CNT-1:0] S_ONE  = NB_TICK_CNT'(1);
    localparam logic [NB_TICK_CNT-1:0] S_MID  = NB_TICK_CNT'(MID_SAMPLE);
    localparam logic [NB_TICK_CNT-1:0] S_BIT  = NB_TICK_CNT'(OVERSAMPLE - 1);
    localparam logic [NB_TICK_CNT-1:0] S_STOP = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0]  N_ONE  = NB_BIT_CNT'(1);
    localparam logic [NB_BIT_CNT-1:0]  N_LAST = NB_BIT_CNT'(NB_DATA - 1);

    state_e                 state_q, state_d;
    logic [NB_TICK_CNT-1:0] s_q, s_d;
    logic [NB_BIT_CNT-1:0]  n_q, n_d;
    logic [NB_DATA-1:0]     shift_q, shift_d;
    logic [NB_DATA-1:0]     data_q, data_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_done_q, rx_done_d;
    logic                   rx_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            rx_done_q   <= rx_done_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bit_q, parity_bit_d;
    logic parity_err_q, parity_err_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

    // Every state except IDLE advances only on tick cycles; the line is judged at mid-bit.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shift_d     = shift_q;
        data_d      = data_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == S_MID) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (s_q == S_BIT) begin
                        s_d          = '0;
                        parity_bit_d = rx_s;
                        state_d      = STOP;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
`endif
            STOP: begin
                if (i_tick) begin
                    if (s_q == S_STOP) begin
                        data_d      = shift_q;
                        frame_err_d = ~rx_s;
                        rx_done_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = (^shift_q) ^ parity_bit_q;
`endif
                        state_d     = IDLE;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are described at the bit level and the model
// predicts each done strobe's cycle and contents from frame length and sync latency.
module tb_uart_rx;

    localparam int NB_DATA = 8;
    localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_TICKS = 16;
    localparam bit HAS_PAR   = 1'b1;
`else
    localparam int PAR_TICKS = 0;
    localparam bit HAS_PAR   = 1'b0;
`endif
    // Ticks from the first tick after leaving IDLE to the final stop tick.
    localparam int FRAME_TICKS  = 8 + 16 * NB_DATA + PAR_TICKS + SB_TICK;
    // Two synchroniser flops, one cycle to leave IDLE, then the frame ticks with i_tick held high.
    localparam int DONE_LATENCY = FRAME_TICKS + 3;

    typedef struct {
        int         doneCycle;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_tick;
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;
    logic               o_parity_err;

    int         cyc = 0;
    exp_t       expQ[$];
    logic [7:0] heldData;
    logic       heldFerr;
    logic       heldPerr;
    logic       expDone;
    int         doneCount;
    int         lastDoneCycle;
    int         assertCount;
    int         failCount;
    bit         checkEn;

    uart_rx #(
        .NB_DATA    (NB_DATA),
        .SB_TICK    (SB_TICK),
        .NB_TICK_CNT(5)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One line cycle: the new level is driven just after the rising edge.
    task automatic driveBit(input logic b);
        @(posedge i_clk);
        #1;
        i_rx = b;
    endtask

    task automatic idle(input int n);
        repeat (n) driveBit(1'b1);
    endtask

    // Sends one whole frame and queues the strobe it must produce.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input int stopLen,
                                 input logic parWrong, output int startCycle);
        exp_t e;
        logic parBit;
        parBit = (^d) ^ parWrong;
        driveBit(1'b0);
        startCycle  = cyc;
        e.doneCycle = cyc + DONE_LATENCY;
        e.data      = d;
        e.ferr      = ~stopBit;
        e.perr      = HAS_PAR ? ((^d) ^ parBit) : 1'b0;
        expQ.push_back(e);
        repeat (15) driveBit(1'b0);
        for (int i = 0; i < NB_DATA; i++) repeat (16) driveBit(d[i]);
        if (HAS_PAR) repeat (16) driveBit(parBit);
        repeat (stopLen) driveBit(stopBit);
    endtask

    // Compare process: strobe timing and held output values, every cycle.
    always @(negedge i_clk) begin
        if (checkEn) begin
            expDone = (expQ.size() > 0) && (expQ[0].doneCycle == cyc);
            if (o_rx_done === 1'b1) begin
                lastDoneCycle = cyc;
                doneCount++;
            end
            checkOutput("rx_done", 32'(o_rx_done), 32'(expDone));
            if (expDone) begin
                heldData = expQ[0].data;
                heldFerr = expQ[0].ferr;
                heldPerr = expQ[0].perr;
                void'(expQ.pop_front());
            end else if (expQ.size() > 0 && expQ[0].doneCycle < cyc) begin
                void'(expQ.pop_front());
            end
            checkOutput("data", 32'(o_data), 32'(heldData));
            checkOutput("frame_err", 32'(o_frame_err), 32'(heldFerr));
            checkOutput("parity_err", 32'(o_parity_err), 32'(heldPerr));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int base;
        logic [7:0] rd;
        logic badStop;
        int stopLen;
        int gap;

        i_reset = 1'b1;
        i_tick  = 1'b1;
        i_rx    = 1'b1;
        checkEn = 1'b0;
        heldData = '0;
        heldFerr = 1'b0;
        heldPerr = 1'b0;
        doneCount = 0;
        lastDoneCycle = 0;
        assertCount = 0;
        failCount = 0;

        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_data", 32'(o_data), 32'h0);
        checkOutput("reset_done", 32'(o_rx_done), 32'h0);
        checkOutput("reset_ferr", 32'(o_frame_err), 32'h0);
        checkOutput("reset_perr", 32'(o_parity_err), 32'h0);
        i_reset = 1'b0;
        checkEn = 1'b1;
        idle(5);

        // 0x55, clean stop: exact strobe latency pinned as a literal.
        base = doneCount;
        applyStimulus(8'h55, 1'b1, 16, 1'b0, k);
        idle(4);
        checkOutput("t55_data", 32'(o_data), 32'h55);
        checkOutput("t55_ferr", 32'(o_frame_err), 32'h0);
        checkOutput("t55_pulses", 32'(doneCount - base), 32'd1);
        checkOutput("t55_latency", 32'(lastDoneCycle - k), HAS_PAR ? 32'd171 : 32'd155);

        // Short low glitch: rejected at mid start bit, no strobe.
        base = doneCount;
        repeat (4) driveBit(1'b0);
        idle(30);
        checkOutput("glitch_pulses", 32'(doneCount - base), 32'd0);
        checkOutput("glitch_data", 32'(o_data), 32'h55);

        // Bad stop bit, then a good frame clears the flag.
        applyStimulus(8'hA3, 1'b0, 16, 1'b0, k);
        idle(6);
        checkOutput("a3_data", 32'(o_data), 32'hA3);
        checkOutput("a3_ferr", 32'(o_frame_err), 32'h1);
        applyStimulus(8'h3C, 1'b1, 16, 1'b0, k);
        idle(4);
        checkOutput("3c_data", 32'(o_data), 32'h3C);
        checkOutput("3c_ferr", 32'(o_frame_err), 32'h0);

        // Reset after three data bits of 0xFF discards the partial frame.
        base = doneCount;
        repeat (16) driveBit(1'b0);
        repeat (48) driveBit(1'b1);
        @(posedge i_clk);
        #1;
        i_reset  = 1'b1;
        i_rx     = 1'b1;
        heldData = '0;
        heldFerr = 1'b0;
        heldPerr = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midrst_data", 32'(o_data), 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        idle(10);
        applyStimulus(8'h0F, 1'b1, 16, 1'b0, k);
        idle(4);
        checkOutput("0f_pulses", 32'(doneCount - base), 32'd1);
        checkOutput("0f_data", 32'(o_data), 32'h0F);

        // Break: line low for a whole frame; the follow-on start is rejected once the line rises.
        base = doneCount;
        applyStimulus(8'h00, 1'b0, 16, 1'b0, k);
        idle(30);
        checkOutput("break_pulses", 32'(doneCount - base), 32'd1);
        checkOutput("break_data", 32'(o_data), 32'h00);
        checkOutput("break_ferr", 32'(o_frame_err), 32'h1);

        // Back-to-back frames with no idle gap.
        base = doneCount;
        applyStimulus(8'h00, 1'b1, 16, 1'b0, k);
        applyStimulus(8'hFF, 1'b1, 16, 1'b0, k);
        idle(4);
        checkOutput("b2b_pulses", 32'(doneCount - base), 32'd2);
        checkOutput("b2b_data", 32'(o_data), 32'hFF);
        checkOutput("b2b_ferr", 32'(o_frame_err), 32'h0);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 16, 1'b1, k);
        idle(4);
        checkOutput("par07_p0_perr", 32'(o_parity_err), 32'h1);
        applyStimulus(8'h07, 1'b1, 16, 1'b0, k);
        idle(4);
        checkOutput("par07_p1_perr", 32'(o_parity_err), 32'h0);
`endif

        // Randomized frames: short stop bits let the next start land on the return to IDLE.
        for (int f = 0; f < 16; f++) begin
            rd      = 8'($urandom);
            badStop = ($urandom_range(0, 3) == 0);
            stopLen = badStop ? 16 : $urandom_range(9, 16);
            if (badStop) gap = $urandom_range(4, 12);
            else         gap = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 12);
            applyStimulus(rd, ~badStop, stopLen, 1'($urandom_range(0, 1)), k);
            idle(gap);
        end

        idle(200);
        checkOutput("pending_frames", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
